otter_cu_mc_fsm: RTL and testbench
==================================

# otter_cu_mc_fsm

Multi-cycle control-unit FSM for the OTTER core, successor to the single-interrupt control FSM. Adds variable-latency instruction/data memory handshakes with a timeout, `NUM_IRQ` edge-triggered prioritised interrupt channels with per-channel masking, and synchronous exceptions for illegal opcodes and memory faults. Sits between the decoder/datapath, the memories and the CSR file. It drives the write enables, memory enables and trap signalling.

## Interface
- `NUM_IRQ`, 4: interrupt channels, 1..16; channel 0 has the highest priority.
- `MEM_TIMEOUT`, 8: maximum wait cycles on a memory access before a fault. 0 disables the timeout.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `instrn` in 32: current instruction; opcode and funct3 are decoded with the `otter_defines.vh` macros.
- `imem_rdy` in 1: instruction memory has data this cycle.
- `dmem_rdy` in 1: data memory has completed the read or write this cycle.
- `irq_in` in `NUM_IRQ`: interrupt request lines, level input; a rising edge is recorded as pending.
- `irq_mask` in `NUM_IRQ`: per-channel enable; 1 means enabled.
- `irq_gie` in 1: global interrupt enable (mstatus.MIE).
- `pc_w_en`, `rfile_w_en`, `dmem_w_en`, `imem_r_en`, `dmem_r_en`, `csr_we` out 1: datapath enables.
- `trap_taken` out 1: high for one cycle while a trap is entered.
- `trap_irq` out 1: the trap is an interrupt (1) or an exception (0).
- `trap_cause` out 4: channel index or exception code.
- `irq_ack` out `NUM_IRQ`: one-hot acknowledge of the serviced channel.

## Operation
- States: INIT, FETCH, EXEC, MEM, WR_BK, TRAP.
- INIT:
  - all outputs 0, including `pc_w_en`;
  - next state is FETCH.
- FETCH:
  - drives `imem_r_en`=1 and `pc_w_en`=0;
  - stays in FETCH until `imem_rdy`=1, then goes to EXEC;
  - on timeout goes to TRAP with cause 1 (instruction access fault).
- EXEC, per opcode, with `pc_w_en`=1 unless stated:
  - OP_REG, OP_IMM, JALR, LUI, AUIPC, JAL: `rfile_w_en`=1.
  - BRANCH: no register write.
  - SYS, funct3 ∈ {001, 101}: `csr_we`=1 and `rfile_w_en`=1.
  - SYS, funct3=000: no-op.
  - LOAD or STORE: `pc_w_en`=0, then go to MEM.
  - Any other opcode, or any other SYS funct3: illegal. All enables are 0 and the next state is TRAP with cause 2.
- MEM:
  - Load: holds `dmem_r_en`=1 until `dmem_rdy`, then goes to WR_BK.
  - Store: holds `dmem_w_en`=1. On `dmem_rdy`, asserts `pc_w_en`=1 that cycle and the instruction completes.
  - On timeout goes to TRAP with cause 5 (load) or 7 (store), `pc_w_en`=0.
- WR_BK: `rfile_w_en`=1 and `pc_w_en`=1; the instruction completes.
- On instruction completion the next state is TRAP if an interrupt is eligible, otherwise FETCH. Completion happens in EXEC for non-memory legal instructions, in MEM for a store, and in WR_BK for a load.
- Interrupt eligibility: `irq_gie` && |(pending & `irq_mask`). The winner is the lowest set index.
- TRAP:
  - outputs `trap_taken`=1 and `pc_w_en`=1 (the PC mux selects mtvec);
  - drives `trap_irq`, `trap_cause` and `irq_ack` from the values latched on entry;
  - next state is FETCH.
- Outside TRAP, `trap_irq`, `trap_cause` and `irq_ack` are 0.
- Exceptions take priority over interrupts. A pending interrupt stays pending through an exception trap.
- Pending bits:
  - set on a rising edge of `irq_in[i]`;
  - cleared at the end of a TRAP cycle whose `irq_ack[i]`=1;
  - if set and clear coincide, set wins.
- Masked channels stay pending.

## Timing
- Reset (asynchronous):
  - state is INIT;
  - pending, edge-history and wait counter are 0;
  - all outputs are 0.
- Because the edge history resets to 0, a line that is already high at reset release registers as an edge on the first clock.
- Zero-wait memory, `rdy` already high on the first cycle:
  - ALU instruction: 2 cycles (FETCH, EXEC).
  - Store: 3 cycles.
  - Load: 4 cycles.
- Each wait cycle adds 1.
- Wait counter:
  - width `$clog2(MEM_TIMEOUT+1)`;
  - cleared on entry to FETCH or MEM;
  - increments on each cycle with `rdy`=0.
- Timeout fires when the counter equals `MEM_TIMEOUT`-1 and `rdy`=0. The access lasts exactly `MEM_TIMEOUT` cycles, then the FSM enters TRAP.
- An interrupt edge at clock n is pending at n+1. It is taken at the first completion at or after n+1.
- Trap entry latency from completion is 1 cycle. `irq_ack` lasts exactly 1 cycle.
- Reset asserted in any state, including mid-MEM, aborts the access with no further enables.

## Structure
- Add to `otter_defines.vh`:
  - state encodings ST_INIT through ST_TRAP (3-bit);
  - cause constants CAUSE_IFAULT=1, CAUSE_ILLEGAL=2, CAUSE_LFAULT=5, CAUSE_SFAULT=7.
- Sub-module `otter_irq_pend`, parametrised by `NUM_IRQ`:
  - edge detect, pending register, mask/GIE qualification;
  - priority encoder outputting `irq_vld` and `irq_idx`;
  - clear input taking the one-hot ack.
- The FSM, wait counter and cause latch live in the top module.

## Test plan
- ALU op (0x00500093) with `imem_rdy` tied 1 -> EXEC one cycle after FETCH; `rfile_w_en`=1 and `pc_w_en`=1 there; 2-cycle loop.
- Load with `dmem_rdy` low 3 cycles -> MEM lasts 4 cycles; WR_BK has `rfile_w_en`=1 and `pc_w_en`=1; `dmem_r_en` is held throughout MEM.
- `MEM_TIMEOUT`=8, `imem_rdy` stuck at 0 -> TRAP after exactly 8 FETCH cycles; `trap_cause`=1, `trap_irq`=0.
- Opcode 0x7F -> no enables in EXEC; TRAP next cycle with cause 2.
- `irq_in`=0b0110 rising together, mask=0b1111, `irq_gie`=1 -> first trap has cause 1 and `irq_ack`=0b0010; the next completion traps with cause 2.
- Rising edge on a masked channel 3, then unmask 10 cycles later -> trap at the next completion with cause 3. Asserting `rst` mid-MEM -> INIT with all outputs 0 immediately.

Source files
------------

// File: rtl/otter_cu_mc_fsm_pkg.sv
// Shared types and constants for the OTTER multi-cycle control unit:
// state encoding, trap cause codes, opcodes and the instruction classifier.
package otter_cu_mc_fsm_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WR_BK = 3'd4,
    ST_TRAP  = 3'd5
  } state_t;

  localparam logic [3:0] CAUSE_IFAULT  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_LFAULT  = 4'd5;
  localparam logic [3:0] CAUSE_SFAULT  = 4'd7;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP_REG = 7'b0110011;
  localparam logic [6:0] OPC_SYS    = 7'b1110011;

  // What the control unit has to do with an instruction in EXEC.
  typedef enum logic [2:0] {
    CL_ALU,      // register write + PC advance
    CL_BRANCH,   // PC advance only
    CL_CSR,      // CSR write + register write + PC advance
    CL_NOP,      // SYS funct3=000: PC advance only
    CL_LOAD,
    CL_STORE,
    CL_ILLEGAL
  } iclass_t;

  function automatic iclass_t decode_class(input logic [6:0] opc, input logic [2:0] funct3);
    iclass_t cls;
    case (opc)
      OPC_OP_REG, OPC_OP_IMM, OPC_JALR,
      OPC_LUI, OPC_AUIPC, OPC_JAL:       cls = CL_ALU;
      OPC_BRANCH:                        cls = CL_BRANCH;
      OPC_LOAD:                          cls = CL_LOAD;
      OPC_STORE:                         cls = CL_STORE;
      OPC_SYS: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) cls = CL_CSR;
        else if (funct3 == 3'b000)                cls = CL_NOP;
        else                                      cls = CL_ILLEGAL;
      end
      default:                           cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/otter_irq_pend.sv
// Interrupt front end: rising-edge capture into sticky pending bits,
// mask/GIE qualification and a lowest-index-wins priority encoder.
module otter_irq_pend
  import otter_cu_mc_fsm_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_IRQ-1:0] i_irq_in,
  input  logic [NUM_IRQ-1:0] i_irq_mask,
  input  logic               i_irq_gie,
  input  logic [NUM_IRQ-1:0] i_clr,
  output logic               o_irq_vld,
  output logic [3:0]         o_irq_idx
);

  logic [NUM_IRQ-1:0] r_hist;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_elig;

  assign w_rise = i_irq_in & ~r_hist;
  assign w_elig = r_pend & i_irq_mask & {NUM_IRQ{i_irq_gie}};

  // Edge history and pending bits; a new edge beats a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hist <= '0;
      r_pend <= '0;
    end else begin
      r_hist <= i_irq_in;
      r_pend <= (r_pend & ~i_clr) | w_rise;
    end
  end

  // Priority encoder: scan from the top so the lowest eligible index is left.
  always_comb begin
    o_irq_vld = |w_elig;
    o_irq_idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) o_irq_idx = 4'(i);
    end
  end

endmodule

// File: rtl/otter_cu_mc_fsm.sv
// OTTER multi-cycle control unit: FETCH/EXEC/MEM/WR_BK sequencing with
// variable-latency memory handshakes, access timeout, synchronous
// exceptions and prioritised edge-triggered interrupts.
module otter_cu_mc_fsm
  import otter_cu_mc_fsm_pkg::*;
#(
  parameter int NUM_IRQ     = 4,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [31:0]        i_instrn,
  input  logic               i_imem_rdy,
  input  logic               i_dmem_rdy,
  input  logic [NUM_IRQ-1:0] i_irq_in,
  input  logic [NUM_IRQ-1:0] i_irq_mask,
  input  logic               i_irq_gie,
  output logic               o_pc_w_en,
  output logic               o_rfile_w_en,
  output logic               o_dmem_w_en,
  output logic               o_imem_r_en,
  output logic               o_dmem_r_en,
  output logic               o_csr_we,
  output logic               o_trap_taken,
  output logic               o_trap_irq,
  output logic [3:0]         o_trap_cause,
  output logic [NUM_IRQ-1:0] o_irq_ack
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_store;
  logic               r_trap_irq;
  logic [3:0]         r_trap_cause;
  logic [NUM_IRQ-1:0] r_trap_ack;

  iclass_t            w_class;
  logic               w_rdy;
  logic               w_timeout;
  logic               w_complete;
  logic [3:0]         w_exc_cause;
  logic               w_irq_vld;
  logic [3:0]         w_irq_idx;
  logic [NUM_IRQ-1:0] w_clr;
  logic               w_unused_instr;

  assign w_class        = decode_class(i_instrn[6:0], i_instrn[14:12]);
  assign w_unused_instr = ^{i_instrn[31:15], i_instrn[11:7]};

  // The handshake that matters depends on which access is in flight.
  assign w_rdy = (r_state == ST_FETCH) ? i_imem_rdy :
                 (r_state == ST_MEM)   ? i_dmem_rdy : 1'b1;

  assign w_timeout = (MEM_TIMEOUT != 0) &&
                     (r_state == ST_FETCH || r_state == ST_MEM) &&
                     !w_rdy && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Pending bits of the serviced channel drop at the end of the TRAP cycle.
  assign w_clr = (r_state == ST_TRAP) ? r_trap_ack : '0;

  otter_irq_pend #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_pend (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_irq_in   (i_irq_in),
    .i_irq_mask (i_irq_mask),
    .i_irq_gie  (i_irq_gie),
    .i_clr      (w_clr),
    .o_irq_vld  (w_irq_vld),
    .o_irq_idx  (w_irq_idx)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_INIT;
    else       r_state <= w_next;
  end

  // Next state; exceptions never complete, so they naturally beat interrupts.
  always_comb begin
    w_next      = r_state;
    w_complete  = 1'b0;
    w_exc_cause = 4'd0;
    case (r_state)
      ST_INIT:  w_next = ST_FETCH;
      ST_FETCH: begin
        if (i_imem_rdy) begin
          w_next = ST_EXEC;
        end else if (w_timeout) begin
          w_next      = ST_TRAP;
          w_exc_cause = CAUSE_IFAULT;
        end
      end
      ST_EXEC: begin
        case (w_class)
          CL_LOAD, CL_STORE: w_next = ST_MEM;
          CL_ILLEGAL: begin
            w_next      = ST_TRAP;
            w_exc_cause = CAUSE_ILLEGAL;
          end
          default:           w_complete = 1'b1;
        endcase
      end
      ST_MEM: begin
        if (i_dmem_rdy) begin
          if (r_is_store) w_complete = 1'b1;
          else            w_next     = ST_WR_BK;
        end else if (w_timeout) begin
          w_next      = ST_TRAP;
          w_exc_cause = r_is_store ? CAUSE_SFAULT : CAUSE_LFAULT;
        end
      end
      ST_WR_BK: w_complete = 1'b1;
      ST_TRAP:  w_next = ST_FETCH;
      default:  w_next = ST_INIT;
    endcase
    if (w_complete) w_next = w_irq_vld ? ST_TRAP : ST_FETCH;
  end

  // Outputs; trap signalling is only visible while in TRAP.
  always_comb begin
    o_pc_w_en    = 1'b0;
    o_rfile_w_en = 1'b0;
    o_dmem_w_en  = 1'b0;
    o_imem_r_en  = 1'b0;
    o_dmem_r_en  = 1'b0;
    o_csr_we     = 1'b0;
    o_trap_taken = 1'b0;
    o_trap_irq   = 1'b0;
    o_trap_cause = 4'd0;
    o_irq_ack    = '0;
    case (r_state)
      ST_FETCH: o_imem_r_en = 1'b1;
      ST_EXEC: begin
        case (w_class)
          CL_ALU: begin
            o_pc_w_en    = 1'b1;
            o_rfile_w_en = 1'b1;
          end
          CL_BRANCH, CL_NOP: o_pc_w_en = 1'b1;
          CL_CSR: begin
            o_pc_w_en    = 1'b1;
            o_rfile_w_en = 1'b1;
            o_csr_we     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (r_is_store) begin
          o_dmem_w_en = 1'b1;
          o_pc_w_en   = i_dmem_rdy;
        end else begin
          o_dmem_r_en = 1'b1;
        end
      end
      ST_WR_BK: begin
        o_rfile_w_en = 1'b1;
        o_pc_w_en    = 1'b1;
      end
      ST_TRAP: begin
        o_trap_taken = 1'b1;
        o_pc_w_en    = 1'b1;
        o_trap_irq   = r_trap_irq;
        o_trap_cause = r_trap_cause;
        o_irq_ack    = r_trap_ack;
      end
      default: ;
    endcase
  end

  // Wait counter: restarts on entering an access, counts not-ready cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if ((w_next == ST_FETCH || w_next == ST_MEM) && w_next != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == ST_FETCH || r_state == ST_MEM) && !w_rdy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Remember load vs store across MEM so a changing instruction bus is harmless.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  r_is_store <= 1'b0;
    else if (r_state == ST_EXEC) r_is_store <= (w_class == CL_STORE);
  end

  // Trap latch: capture kind, cause and acknowledge on the way into TRAP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_trap_irq   <= 1'b0;
      r_trap_cause <= 4'd0;
      r_trap_ack   <= '0;
    end else if (w_next == ST_TRAP) begin
      r_trap_irq   <= w_complete;
      r_trap_cause <= w_complete ? w_irq_idx : w_exc_cause;
      r_trap_ack   <= w_complete ? (NUM_IRQ'(1) << w_irq_idx) : '0;
    end
  end

endmodule

// File: tb/tb_otter_cu_mc_fsm.sv
// Bench for otter_cu_mc_fsm: directed scenarios followed by randomized
// instruction streams, all checked cycle by cycle against an
// instruction-level reference model with its own pending-interrupt state.
module tb_otter_cu_mc_fsm;

  localparam int NIRQ = 4;
  localparam int MT   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrn;
  logic        imem_rdy, dmem_rdy;
  logic [3:0]  irq_in, irq_mask;
  logic        irq_gie;
  logic        pc_w_en, rfile_w_en, dmem_w_en, imem_r_en, dmem_r_en, csr_we;
  logic        trap_taken, trap_irq;
  logic [3:0]  trap_cause;
  logic [3:0]  irq_ack;
  logic [15:0] obs;

  int errors = 0;
  int checks = 0;

  logic [3:0] m_pend, m_prev;
  bit         rnd_irq;

  always #5 clk = ~clk;

  otter_cu_mc_fsm #(.NUM_IRQ(NIRQ), .MEM_TIMEOUT(MT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_instrn     (instrn),
    .i_imem_rdy   (imem_rdy),
    .i_dmem_rdy   (dmem_rdy),
    .i_irq_in     (irq_in),
    .i_irq_mask   (irq_mask),
    .i_irq_gie    (irq_gie),
    .o_pc_w_en    (pc_w_en),
    .o_rfile_w_en (rfile_w_en),
    .o_dmem_w_en  (dmem_w_en),
    .o_imem_r_en  (imem_r_en),
    .o_dmem_r_en  (dmem_r_en),
    .o_csr_we     (csr_we),
    .o_trap_taken (trap_taken),
    .o_trap_irq   (trap_irq),
    .o_trap_cause (trap_cause),
    .o_irq_ack    (irq_ack)
  );

  assign obs = {pc_w_en, rfile_w_en, dmem_w_en, imem_r_en, dmem_r_en, csr_we,
                trap_taken, trap_irq, trap_cause, irq_ack};

  function automatic logic [15:0] mk(bit pc, bit rf, bit dw, bit ir, bit dr, bit csr);
    return {pc, rf, dw, ir, dr, csr, 10'b0};
  endfunction

  function automatic logic [15:0] mk_trap(bit ti, logic [3:0] c, logic [3:0] a);
    return {1'b1, 5'b0, 1'b1, ti, c, a};
  endfunction

  function automatic logic [31:0] mkins(logic [6:0] opc, logic [2:0] f3);
    logic [31:0] v;
    v = $urandom;
    v[6:0]   = opc;
    v[14:12] = f3;
    return v;
  endfunction

  // Lowest enabled pending channel, or -1 when nothing is eligible.
  function automatic int winner();
    if (!irq_gie) return -1;
    for (int i = 0; i < NIRQ; i++)
      if (m_pend[i] && irq_mask[i]) return i;
    return -1;
  endfunction

  task automatic check(input logic [15:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are set at the falling edge, outputs sampled
  // just after, and the pending model advanced across the coming rising edge.
  task automatic step(input logic [15:0] exp, input string tag);
    if (rnd_irq && $urandom_range(0, 5) == 0)
      irq_in = irq_in ^ (4'b0001 << $urandom_range(0, 3));
    #1;
    check(exp, tag);
    m_pend = (m_pend & ~exp[3:0]) | (irq_in & ~m_prev);
    m_prev = irq_in;
    @(negedge clk);
  endtask

  // Completion cycle, followed by an interrupt trap if one is eligible.
  task automatic complete(input logic [15:0] exp, input string tag);
    int w;
    w = winner();
    step(exp, tag);
    if (w >= 0) step(mk_trap(1'b1, 4'(w), 4'(1 << w)), "irq_trap");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check(16'h0, "reset_immediate");
    @(negedge clk);
    #1;
    check(16'h0, "reset_hold");
    @(negedge clk);
    rst = 1'b0;
    m_pend = '0;
    m_prev = '0;
    step(16'h0, "init");
  endtask

  // Run one instruction from FETCH, with iw fetch wait cycles and dw data wait cycles.
  task automatic do_instr(input logic [31:0] ins, input int iw, input int dw);
    logic [6:0] opc;
    logic [2:0] f3;
    bit         st;
    opc    = ins[6:0];
    f3     = ins[14:12];
    instrn = ins;
    for (int k = 0; k < 64; k++) begin
      imem_rdy = (k >= iw);
      if (!imem_rdy && k == MT - 1) begin
        step(mk(0, 0, 0, 1, 0, 0), "fetch_last");
        step(mk_trap(1'b0, 4'd1, 4'd0), "ifault_trap");
        return;
      end
      step(mk(0, 0, 0, 1, 0, 0), "fetch");
      if (imem_rdy) break;
    end
    imem_rdy = 1'($urandom_range(0, 1));
    case (opc)
      7'h33, 7'h13, 7'h67, 7'h37, 7'h17, 7'h6F:
        complete(mk(1, 1, 0, 0, 0, 0), "exec_alu");
      7'h63:
        complete(mk(1, 0, 0, 0, 0, 0), "exec_branch");
      7'h73: begin
        if (f3 == 3'b001 || f3 == 3'b101) complete(mk(1, 1, 0, 0, 0, 1), "exec_csr");
        else if (f3 == 3'b000)            complete(mk(1, 0, 0, 0, 0, 0), "exec_sys_nop");
        else begin
          step(16'h0, "exec_sys_illegal");
          step(mk_trap(1'b0, 4'd2, 4'd0), "illegal_trap");
        end
      end
      7'h03, 7'h23: begin
        st = (opc == 7'h23);
        step(16'h0, "exec_mem");
        for (int k = 0; k < 64; k++) begin
          dmem_rdy = (k >= dw);
          if (!dmem_rdy && k == MT - 1) begin
            step(st ? mk(0, 0, 1, 0, 0, 0) : mk(0, 0, 0, 0, 1, 0), "mem_last");
            step(mk_trap(1'b0, st ? 4'd7 : 4'd5, 4'd0), "dfault_trap");
            return;
          end
          if (dmem_rdy) begin
            if (st) begin
              complete(mk(1, 0, 1, 0, 0, 0), "store_done");
            end else begin
              step(mk(0, 0, 0, 0, 1, 0), "load_done");
              dmem_rdy = 1'($urandom_range(0, 1));
              complete(mk(1, 1, 0, 0, 0, 0), "wr_bk");
            end
            break;
          end
          step(st ? mk(0, 0, 1, 0, 0, 0) : mk(0, 0, 0, 0, 1, 0), "mem_wait");
        end
      end
      default: begin
        step(16'h0, "exec_illegal");
        step(mk_trap(1'b0, 4'd2, 4'd0), "illegal_trap");
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] opcs [12];
    logic [6:0] opc;
    int iw, dw;
    opcs = '{7'h33, 7'h13, 7'h67, 7'h37, 7'h17, 7'h6F,
             7'h63, 7'h73, 7'h03, 7'h23, 7'h7F, 7'h0B};

    rst      = 1'b1;
    instrn   = 32'h0;
    imem_rdy = 1'b0;
    dmem_rdy = 1'b0;
    irq_in   = 4'h0;
    irq_mask = 4'h0;
    irq_gie  = 1'b0;
    rnd_irq  = 1'b0;
    m_pend   = '0;
    m_prev   = '0;

    do_reset();

    // ALU op, zero-wait fetch: two-cycle loop
    do_instr(32'h00500093, 0, 0);
    do_instr(32'h00500093, 0, 0);
    // Load with three data wait cycles, then zero-wait load and store
    do_instr(32'h00002083, 0, 3);
    do_instr(32'h00002083, 1, 0);
    do_instr(32'h00102023, 0, 0);
    do_instr(32'h00102023, 2, 2);
    // Branch, CSR ops and SYS no-op
    do_instr(mkins(7'h63, 3'b000), 0, 0);
    do_instr(mkins(7'h73, 3'b001), 0, 0);
    do_instr(mkins(7'h73, 3'b101), 0, 0);
    do_instr(mkins(7'h73, 3'b000), 0, 0);
    // Fetch timeout, load and store timeouts, just-in-time ready
    do_instr(32'h00500093, 100, 0);
    do_instr(32'h00002083, 0, 100);
    do_instr(32'h00102023, 0, 100);
    do_instr(32'h00500093, MT - 1, 0);
    // Illegal opcode and illegal SYS funct3
    do_instr(32'h0000007F, 0, 0);
    do_instr(mkins(7'h73, 3'b010), 0, 0);

    // Two channels rise together: channel 1 first, then channel 2
    irq_mask = 4'b1111;
    irq_gie  = 1'b1;
    irq_in   = 4'b0110;
    do_instr(32'h00500093, 0, 0);
    do_instr(32'h00500093, 0, 0);
    do_instr(32'h00500093, 0, 0);

    // Exception beats a pending interrupt, which survives it
    irq_in = 4'b0111;
    do_instr(32'h0000007F, 0, 0);
    do_instr(32'h00500093, 0, 0);

    // Masked channel 3 stays pending until unmasked
    irq_mask = 4'b0111;
    irq_in   = 4'b1111;
    for (int i = 0; i < 5; i++) do_instr(32'h00500093, 0, 0);
    irq_mask = 4'b1111;
    do_instr(32'h00500093, 0, 0);
    do_instr(32'h00500093, 0, 0);

    // Reset in the middle of a load
    instrn   = 32'h00002083;
    imem_rdy = 1'b1;
    dmem_rdy = 1'b0;
    step(mk(0, 0, 0, 1, 0, 0), "pre_rst_fetch");
    step(16'h0, "pre_rst_exec");
    step(mk(0, 0, 0, 0, 1, 0), "pre_rst_mem");
    step(mk(0, 0, 0, 0, 1, 0), "pre_rst_mem");
    do_reset();

    // Lines high at reset release count as edges on the first clock
    do_instr(32'h00500093, 0, 0);
    do_instr(32'h00500093, 0, 0);

    // Randomized instruction stream with random waits, edges and masking
    rnd_irq = 1'b1;
    for (int n = 0; n < 200; n++) begin
      opc = opcs[$urandom_range(0, 11)];
      iw  = ($urandom_range(0, 9) == 0) ? 6 + $urandom_range(0, 4) : $urandom_range(0, 3);
      dw  = ($urandom_range(0, 9) == 0) ? 6 + $urandom_range(0, 4) : $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) irq_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) irq_gie  = ~irq_gie;
      do_instr(mkins(opc, 3'($urandom_range(0, 7))), iw, dw);
    end
    rnd_irq = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
